mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
//   arb_state_e      : arbiter FSM state (IDLE, WAIT)
//   ARB_ID_IF/ARB_ID_D : requester identifiers (fetch = 0, data = 1)
//   MEM_LATENCY_MAX  : largest supported RAM read latency
//   LAT_CNT_W        : width of the read-latency down-counter
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam logic ARB_ID_IF = 1'b0;
    localparam logic ARB_ID_D  = 1'b1;

    localparam int MEM_LATENCY_MAX = 3;
    localparam int LAT_CNT_W       = $clog2(MEM_LATENCY_MAX + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the two requesters of mem_port_arbiter.
// Purely combinational; the caller decides which requester is favoured on a
// tie (fixed data-over-fetch, or the one not granted last).
// Ports:
//   if_elig_i   : fetch requester is eligible this cycle
//   d_elig_i    : data requester is eligible this cycle
//   prefer_if_i : on a tie, fetch wins (else data wins)
//   if_win_o    : fetch selected
//   d_win_o     : data selected
module mem_arb_pick (
    input  logic if_elig_i,
    input  logic d_elig_i,
    input  logic prefer_if_i,
    output logic if_win_o,
    output logic d_win_o
);

    always_comb begin
        if_win_o = 1'b0;
        d_win_o  = 1'b0;
        if (if_elig_i && d_elig_i) begin
            if (prefer_if_i) begin
                if_win_o = 1'b1;
            end else begin
                d_win_o = 1'b1;
            end
        end else begin
            if_win_o = if_elig_i;
            d_win_o  = d_elig_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared RAM port.
// One read may be outstanding; a new grant is possible in IDLE or in the
// cycle that returns read data, so reads can stream at one per cycle when
// MEM_LATENCY = 1. Writes complete in their grant cycle.
// Configuration macro: MEM_ARB_RR_EN -- when defined, ties go to the
// requester not granted last; otherwise data always beats fetch.
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (1..3).
// Ports:
//   clk, resetn                       : clock, synchronous active-low reset
//   if_req, if_addr                   : fetch read request
//   if_gnt, if_rvalid, if_rdata, if_stall : fetch responses
//   d_req, d_we, d_be, d_addr, d_wdata    : data request
//   d_gnt, d_rvalid, d_rdata, d_stall     : data responses
//   mem_en, mem_we, mem_addr, mem_wdata   : shared RAM port (mem_we = byte enables)
//   mem_rdata                         : RAM read data, MEM_LATENCY after enable
//   busy                              : a read is outstanding
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..%0d", MEM_LATENCY_MAX);
    end

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    arb_state_e           state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 owner_q, owner_d;

    logic in_wait;
    logic rvalid_now;
    logic grant_window;
    logic if_elig, d_elig;
    logic if_win, d_win;
    logic gnt_if, gnt_d;
    logic prefer_if;

    // The counter reaches 1 in the cycle the RAM data is valid; all
    // responses are forced low while reset is held.
    assign in_wait      = (state_q == WAIT);
    assign rvalid_now   = resetn && in_wait && (cnt_q == CNT_ONE);
    assign grant_window = !in_wait || rvalid_now;

    // The owner of the outstanding read cannot be granted again until a
    // later cycle, even in its own rvalid cycle.
    assign if_elig = if_req && !(in_wait && owner_q == ARB_ID_IF);
    assign d_elig  = d_req  && !(in_wait && owner_q == ARB_ID_D);

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    assign prefer_if = (last_q == ARB_ID_D);

    always_comb begin
        last_d = last_q;
        if (gnt_d) begin
            last_d = ARB_ID_D;
        end else if (gnt_if) begin
            last_d = ARB_ID_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= ARB_ID_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign prefer_if = 1'b0;
`endif

    mem_arb_pick u_pick (
        .if_elig_i   (if_elig),
        .d_elig_i    (d_elig),
        .prefer_if_i (prefer_if),
        .if_win_o    (if_win),
        .d_win_o     (d_win)
    );

    assign gnt_if = resetn && grant_window && if_win;
    assign gnt_d  = resetn && grant_window && d_win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 1'b1;
            if (rvalid_now) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
        // A read grant (re)enters WAIT; a write leaves the state alone,
        // which is IDLE or the IDLE-bound rvalid cycle.
        if (gnt_if || (gnt_d && !d_we)) begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
            owner_d = gnt_d ? ARB_ID_D : ARB_ID_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= ARB_ID_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        if_gnt    = gnt_if;
        d_gnt     = gnt_d;
        mem_en    = gnt_if || gnt_d;
        mem_we    = (gnt_d && d_we) ? d_be : '0;
        mem_addr  = gnt_d ? d_addr : (gnt_if ? if_addr : '0);
        mem_wdata = gnt_d ? d_wdata : '0;

        if_rvalid = rvalid_now && (owner_q == ARB_ID_IF);
        d_rvalid  = rvalid_now && (owner_q == ARB_ID_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;

        // Fetch is always a read; data is done on rvalid or on a write grant.
        if_stall  = resetn && if_req && !if_rvalid;
        d_stall   = resetn && d_req && !(d_rvalid || (gnt_d && d_we));

        busy      = resetn && in_wait;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NI = 3;
    localparam int OW = 1 + 1 + DW + 1 + 1 + 1 + DW + 1 + 1 + BW + AW + DW + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata;

    logic          if_gnt[NI], if_rvalid[NI], if_stall[NI];
    logic [DW-1:0] if_rdata[NI];
    logic          d_gnt[NI], d_rvalid[NI], d_stall[NI];
    logic [DW-1:0] d_rdata[NI];
    logic          mem_en[NI], busy[NI];
    logic [BW-1:0] mem_we[NI];
    logic [AW-1:0] mem_addr[NI];
    logic [DW-1:0] mem_wdata[NI];
    logic [OW-1:0] obs[NI];

    always #5 clk = ~clk;

    // Instance k has MEM_LATENCY = k+1; all share the same stimulus.
    for (genvar k = 0; k < NI; k++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(k + 1)) u_dut (
            .clk(clk), .resetn(resetn),
            .if_req(if_req), .if_addr(if_addr),
            .if_gnt(if_gnt[k]), .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]), .if_stall(if_stall[k]),
            .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]), .d_stall(d_stall[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
            .mem_rdata(mem_rdata), .busy(busy[k])
        );
        assign obs[k] = {if_gnt[k], if_rvalid[k], if_rdata[k], if_stall[k],
                         d_gnt[k], d_rvalid[k], d_rdata[k], d_stall[k],
                         mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], busy[k]};
    end

    // Reference model: an outstanding read is a (owner, due cycle) pair;
    // requester 0 = fetch, 1 = data.
    typedef struct packed {
        logic pend;
        logic owner;
        logic last;
        int   due;
    } mstate_t;

    mstate_t ms[NI];
    mstate_t nxt[NI];
    int      cyc;
    int      vectors;
    int      miscompares;

    task automatic model_eval(input int k, output logic [OW-1:0] e, output mstate_t n);
        logic due_now, rv_i, rv_d, egi, egd, wi, wd;
        n = ms[k];
        e = '0;
        if (!resetn) begin
            n.pend  = 1'b0;
            n.owner = 1'b0;
            n.last  = 1'b0;
            n.due   = 0;
        end else begin
            due_now = ms[k].pend && (ms[k].due == cyc);
            rv_i    = due_now && (ms[k].owner == 1'b0);
            rv_d    = due_now && (ms[k].owner == 1'b1);
            egi     = if_req && !(ms[k].pend && ms[k].owner == 1'b0);
            egd     = d_req  && !(ms[k].pend && ms[k].owner == 1'b1);
            wi      = 1'b0;
            wd      = 1'b0;
            if (!ms[k].pend || due_now) begin
                if (egi && egd) begin
`ifdef MEM_ARB_RR_EN
                    if (ms[k].last == 1'b1) wi = 1'b1;
                    else                    wd = 1'b1;
`else
                    wd = 1'b1;
`endif
                end else begin
                    wi = egi;
                    wd = egd;
                end
            end
            e = {wi, rv_i, (rv_i ? mem_rdata : 32'h0), (if_req && !rv_i),
                 wd, rv_d, (rv_d ? mem_rdata : 32'h0), (d_req && !(rv_d || (wd && d_we))),
                 (wi || wd), ((wd && d_we) ? d_be : 4'h0),
                 (wd ? d_addr : (wi ? if_addr : 32'h0)), (wd ? d_wdata : 32'h0),
                 ms[k].pend};
            if (due_now) n.pend = 1'b0;
            if (wi || (wd && !d_we)) begin
                n.pend  = 1'b1;
                n.owner = wd;
                n.due   = cyc + k + 1;
            end
            if (wi || wd) n.last = wd;
        end
    endtask

    task automatic settle();
        logic [OW-1:0] e;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            model_eval(k, e, nxt[k]);
            vectors++;
            assert (obs[k] === e) else begin
                miscompares++;
                $error("FAIL model_L%0d cyc=%0d: observed %h expected %h", k + 1, cyc, obs[k], e);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < NI; k++) ms[k] = nxt[k];
        cyc++;
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_zero(input string tag, input int k);
        vectors++;
        assert (obs[k] === '0) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected 0", tag, obs[k]);
        end
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        for (int k = 0; k < NI; k++) begin
            ms[k] = '0;
            nxt[k] = '0;
        end
        resetn = 1'b0; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
        d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h0; mem_rdata = 32'hA5A5A5A5;
        #1;

        // Outputs held low during reset even with requests present.
        settle(); for (int k = 0; k < NI; k++) chk_zero($sformatf("reset_zero_L%0d", k + 1), k); advance();
        tick();
        resetn = 1'b1;
        idle(2);

        // Single fetch, latency 1.
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00500093;
        settle();
        chk("fetch_gnt_t", if_gnt[0], 1); chk("fetch_stall_t", if_stall[0], 1);
        chk("fetch_addr_t", mem_addr[0], 32'h10); chk("fetch_we_t", mem_we[0], 0);
        advance();
        settle();
        chk("fetch_rvalid_t1", if_rvalid[0], 1); chk("fetch_rdata_t1", if_rdata[0], 32'h00500093);
        chk("fetch_stall_t1", if_stall[0], 0); chk("fetch_busy_t1", busy[0], 1);
        advance();
        if_req = 1'b0;
        settle(); chk("fetch_rvalid_t2", if_rvalid[0], 0); chk("fetch_rdata_t2", if_rdata[0], 0); advance();
        idle(4);

        // Simultaneous read requests, fixed priority (data first).
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34; mem_rdata = 32'h11112222;
        settle();
        chk("sim_dgnt_t", d_gnt[0], 1); chk("sim_ifgnt_t", if_gnt[0], 0); chk("sim_addr_t", mem_addr[0], 32'h34);
        advance();
        settle();
        chk("sim_drvalid_t1", d_rvalid[0], 1); chk("sim_ifgnt_t1", if_gnt[0], 1);
        chk("sim_addr_t1", mem_addr[0], 32'h10); chk("sim_drdata_t1", d_rdata[0], 32'h11112222);
        advance();
        d_req = 1'b0;
        settle(); chk("sim_ifrvalid_t2", if_rvalid[0], 1); chk("sim_drvalid_t2", d_rvalid[0], 0); advance();
        idle(5);

        // Latency 3 read: busy three cycles, no grants until the data cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'hCAFE0003;
        settle(); chk("l3_dgnt_t", d_gnt[2], 1); chk("l3_busy_t", busy[2], 0); advance();
        if_req = 1'b1; if_addr = 32'h44;
        for (int i = 1; i <= 2; i++) begin
            settle();
            chk($sformatf("l3_busy_t%0d", i), busy[2], 1);
            chk($sformatf("l3_rvalid_t%0d", i), d_rvalid[2], 0);
            chk($sformatf("l3_nogrant_t%0d", i), {if_gnt[2], d_gnt[2], mem_en[2]}, 0);
            advance();
        end
        settle();
        chk("l3_busy_t3", busy[2], 1); chk("l3_rvalid_t3", d_rvalid[2], 1);
        chk("l3_rdata_t3", d_rdata[2], 32'hCAFE0003); chk("l3_ifgnt_t3", if_gnt[2], 1);
        advance();
        idle(6);

        // Reset in the middle of a latency 2 read drops it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; mem_rdata = 32'h0BADF00D;
        settle(); chk("l2_dgnt_t", d_gnt[1], 1); advance();
        resetn = 1'b0; if_req = 1'b1; if_addr = 32'h60;
        settle(); chk_zero("l2_reset_zero_t1", 1); advance();
        resetn = 1'b1; d_req = 1'b0;
        settle();
        chk("l2_no_rvalid_t2", d_rvalid[1], 0); chk("l2_ifgnt_t2", if_gnt[1], 1);
        chk("l2_addr_t2", mem_addr[1], 32'h60);
        advance();
        idle(6);

        // Writes: full byte enables, then zero byte enables.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
        settle();
        chk("wr_gnt", d_gnt[0], 1); chk("wr_we", mem_we[0], 4'hF); chk("wr_wdata", mem_wdata[0], 32'hDEADBEEF);
        chk("wr_stall", d_stall[0], 0); chk("wr_busy", busy[0], 0);
        advance();
        d_be = 4'h0; d_addr = 32'h84;
        settle();
        chk("wr0_en", mem_en[0], 1); chk("wr0_we", mem_we[0], 0); chk("wr0_gnt", d_gnt[0], 1);
        advance();
        settle(); chk("wr0_no_rvalid", d_rvalid[0], 0); chk("wr0_busy", busy[0], 0); advance();
        idle(2);

        // Simultaneous requests held four cycles with a data write.
        resetn = 1'b0; tick(); resetn = 1'b1;
        if_req = 1'b1; if_addr = 32'h90; d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h94;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifdef MEM_ARB_RR_EN
            chk($sformatf("alt_dgnt_%0d", i), d_gnt[0], (i % 2 == 0) ? 1 : 0);
            chk($sformatf("alt_ifgnt_%0d", i), if_gnt[0], (i % 2 == 1) ? 1 : 0);
`else
            chk($sformatf("fix_dgnt_%0d", i), d_gnt[0], 1);
            chk($sformatf("fix_ifgnt_%0d", i), if_gnt[0], 0);
`endif
            advance();
        end
        idle(5);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            resetn    = ($urandom_range(0, 39) != 0);
            if_req    = ($urandom_range(0, 3) != 0);
            if_addr   = $urandom;
            d_req     = ($urandom_range(0, 2) != 0);
            d_we      = $urandom_range(0, 1);
            d_be      = 4'($urandom_range(0, 15));
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            tick();
        end
        resetn = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
